// File: rtl/data_memory_responder.sv
// Word-addressed data RAM for the core's lw/sw path: requests complete after WAIT_STATES
// wait states with a one-cycle ready pulse. Define DMEM_BYTE_STROBE_EN to add per-byte store strobes.
module data_memory_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memory_read,
  input  logic                  memory_write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]            write_strobe,
`endif
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  access_error
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [DEPTH_LOG2+1:0]   r_addr;
  logic                    r_rd;
  logic                    r_wr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [3:0]              r_strb;
  logic [DATA_WIDTH-1:0]   r_mem [2**DEPTH_LOG2];

  logic                    w_idle;
  logic                    w_req;
  logic [DEPTH_LOG2+1:0]   w_acc_addr;
  logic                    w_acc_rd;
  logic                    w_acc_wr;
  logic [DATA_WIDTH-1:0]   w_acc_data;
  logic [3:0]              w_acc_strb;
  logic [3:0]              w_in_strb;
  logic                    w_acc_err;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic                    w_fire;
  logic                    w_unused;

`ifdef DMEM_BYTE_STROBE_EN
  assign w_in_strb = write_strobe;
`else
  assign w_in_strb = '1;
`endif

  // Upper address bits only alias; they never select anything.
  assign w_unused = ^{address[31:DEPTH_LOG2+2]};

  assign w_idle = (r_state == ST_IDLE);
  assign w_req  = memory_read | memory_write;

  // With zero wait states the access happens on the accepting edge, so it must
  // use the live inputs; otherwise it uses the values latched at acceptance.
  assign w_acc_addr = w_idle ? address[DEPTH_LOG2+1:0] : r_addr;
  assign w_acc_rd   = w_idle ? memory_read  : r_rd;
  assign w_acc_wr   = w_idle ? memory_write : r_wr;
  assign w_acc_data = w_idle ? write_data   : r_wdata;
  assign w_acc_strb = w_idle ? w_in_strb    : r_strb;
  assign w_acc_err  = (w_acc_addr[1:0] != 2'b00) || (w_acc_rd && w_acc_wr);
  assign w_idx      = w_acc_addr[DEPTH_LOG2+1:2];
  assign w_mask     = {{8{w_acc_strb[3]}}, {8{w_acc_strb[2]}},
                       {8{w_acc_strb[1]}}, {8{w_acc_strb[0]}}};
  assign w_fire     = (w_idle && w_req && (WAIT_STATES == 0)) ||
                      ((r_state == ST_WAIT) && (r_cnt == '0));

  always_ff @(posedge clk) begin
    if (rst_n && w_fire && w_acc_wr && !w_acc_err)
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (w_acc_data & w_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_wdata      <= '0;
      r_strb       <= '0;
      read_data    <= '0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      access_error <= 1'b0;
    end else begin
      ready        <= 1'b0;
      access_error <= 1'b0;
      read_data    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= address[DEPTH_LOG2+1:0];
            r_rd    <= memory_read;
            r_wr    <= memory_write;
            r_wdata <= write_data;
            r_strb  <= w_in_strb;
            busy    <= 1'b1;
            r_cnt   <= (WAIT_STATES == 0) ? '0 : 4'(WAIT_STATES - 1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Completion overrides the state chosen above.
      if (w_fire) begin
        r_state      <= ST_RESP;
        ready        <= 1'b1;
        access_error <= w_acc_err;
        read_data    <= (w_acc_rd && !w_acc_err) ? r_mem[w_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with WAIT_STATES=2, DEPTH_LOG2=8.
// Byte-strobe scenario is compiled only when DMEM_BYTE_STROBE_EN is defined.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;
  logic        access_error;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  write_strobe = 4'hF;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_memory_responder #(
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (8),
    .WAIT_STATES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memory_read (memory_read),
    .memory_write(memory_write),
    .address     (address),
    .write_data  (write_data),
`ifdef DMEM_BYTE_STROBE_EN
    .write_strobe(write_strobe),
`endif
    .read_data   (read_data),
    .ready       (ready),
    .busy        (busy),
    .access_error(access_error)
  );

  // Drives one request (called #1 after an edge with the DUT idle), waits for ready
  // within a bounded number of cycles, then leaves the DUT idle again.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic bsy, output logic [31:0] rd_after, output logic busy_after);
    memory_read = rd; memory_write = wr; address = a; write_data = d;
    lat = 0; bsy = 1'b0; rdata = 'x; err = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) bsy = busy;
      if (ready) begin
        lat = i; rdata = read_data; err = access_error;
        break;
      end
    end
    memory_read = 1'b0; memory_write = 1'b0;
    @(posedge clk); #1;
    rd_after = read_data; busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h want 00000000", read_data); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (access_error !== 1'b0) begin n_fail++; $display("FAIL reset_access_error: got %b want 0", access_error); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, rda; logic er, bs, bsa; int lat;
    xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_error: got %b want 0", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_read_data: got %h want 00000000", rd); end
    n_cmp++; if (bs !== 1'b1) begin n_fail++; $display("FAIL sw_busy_after_accept: got %b want 1", bs); end
    xact(1'b1, 1'b0, 32'h10, 32'h0, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_error: got %b want 0", er); end
    n_cmp++; if (rda !== 32'h0) begin n_fail++; $display("FAIL lw_data_clears: got %h want 00000000", rda); end
    n_cmp++; if (bsa !== 1'b0) begin n_fail++; $display("FAIL lw_busy_clears: got %b want 0", bsa); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, rda; logic er, bs, bsa; int lat;
    xact(1'b1, 1'b0, 32'h402, 32'h0, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL mis_lw_latency: got %0d want 3", lat); end
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_lw_error: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_lw_data: got %h want 00000000", rd); end
    xact(1'b0, 1'b1, 32'h4, 32'h01020304, rd, er, lat, bs, rda, bsa);
    xact(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_sw_error: got %b want 1", er); end
    xact(1'b1, 1'b0, 32'h4, 32'h0, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL mis_sw_ram_kept: got %h want 01020304", rd); end
  endtask

  task automatic test_aliasing();
    logic [31:0] rd, rda; logic er, bs, bsa; int lat;
    xact(1'b0, 1'b1, 32'h400, 32'h12345678, rd, er, lat, bs, rda, bsa);
    xact(1'b1, 1'b0, 32'h0, 32'h0, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL alias_data: got %h want 12345678", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL alias_error: got %b want 0", er); end
  endtask

  task automatic test_both_strobes();
    logic [31:0] rd, rda; logic er, bs, bsa; int lat;
    xact(1'b0, 1'b1, 32'h8, 32'h55AA55AA, rd, er, lat, bs, rda, bsa);
    xact(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL both_latency: got %0d want 3", lat); end
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL both_error: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL both_data: got %h want 00000000", rd); end
    xact(1'b1, 1'b0, 32'h8, 32'h0, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL both_ram_kept: got %h want 55aa55aa", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, rda; logic er, bs, bsa; int lat;
    xact(1'b0, 1'b1, 32'h20, 32'h13579BDF, rd, er, lat, bs, rda, bsa);
    memory_write = 1'b1; address = 32'h20; write_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_accepted: got %b want 1", busy); end
    rst_n = 1'b0; memory_write = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(1'b1, 1'b0, 32'h20, 32'h0, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (rd !== 32'h13579BDF) begin n_fail++; $display("FAIL abort_ram_kept: got %h want 13579bdf", rd); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 3", lat); end
  endtask

  task automatic test_back_to_back();
    int first = 0, second = 0;
    logic rdy_next = 1'b1;
    logic [31:0] d2 = 'x;
    memory_read = 1'b1; address = 32'h10;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (first != 0 && i == first + 1) rdy_next = ready;
      if (ready) begin
        if (first == 0) first = i;
        else begin second = i; d2 = read_data; break; end
      end
    end
    memory_read = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (first !== 3) begin n_fail++; $display("FAIL b2b_first: got %0d want 3", first); end
    n_cmp++; if (second - first !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", second - first); end
    n_cmp++; if (rdy_next !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_pulse: got %b want 0", rdy_next); end
    n_cmp++; if (d2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_data: got %h want deadbeef", d2); end
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_byte_strobe();
    logic [31:0] rd, rda; logic er, bs, bsa; int lat;
    write_strobe = 4'hF;
    xact(1'b0, 1'b1, 32'h30, 32'h0, rd, er, lat, bs, rda, bsa);
    write_strobe = 4'b0011;
    xact(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, rd, er, lat, bs, rda, bsa);
    write_strobe = 4'hF;
    xact(1'b1, 1'b0, 32'h30, 32'h0, rd, er, lat, bs, rda, bsa);
    n_cmp++; if (rd !== 32'h0000FFFF) begin n_fail++; $display("FAIL strobe_data: got %h want 0000ffff", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_aliasing();
    test_both_strobes();
    test_reset_abort();
    test_back_to_back();
`ifdef DMEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
